// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART transmitter between
// CPU MMIO stores (requester 0) and the debug/trace engine (requester 1).
module uart_tx_arbiter #(
  parameter int IdleTimeout  = 1024,
  parameter int TimeoutWidth = $clog2(IdleTimeout) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_event
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [TimeoutWidth-1:0] StallLimit = TimeoutWidth'(IdleTimeout);

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              grant_next;
  logic                    prio;
  logic                    prio_next;
  logic [TimeoutWidth-1:0] stall_cnt;
  logic [TimeoutWidth-1:0] stall_next;
  logic [7:0]              tx_data_next;
  logic                    tx_valid_next;
  logic                    free;
  logic                    accept;
  logic                    owner_valid;
  logic                    owner_last;
  logic [7:0]              owner_data;
  logic                    timeout_hit;

  // The output register may take a new byte whenever the transmitter is not
  // still holding off the current one; Ready never looks at the requester's Valid.
  assign free        = !tx_valid || tx_ready;
  assign req0_ready  = grant[0] && free;
  assign req1_ready  = grant[1] && free;
  assign accept      = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  assign owner_valid = grant[1] ? req1_valid : (grant[0] && req0_valid);
  assign owner_last  = grant[1] ? req1_last  : req0_last;
  assign owner_data  = grant[1] ? req1_data  : req0_data;

  // An accept on the expiry cycle keeps the lock, so it suppresses the timeout.
  assign timeout_hit   = (state == LOCKED) && (IdleTimeout != 0) &&
                         (stall_cnt == StallLimit) && !accept;
  assign timeout_event = timeout_hit;
  assign busy          = (state == LOCKED) || tx_valid;

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    prio_next     = prio;
    stall_next    = stall_cnt;
    tx_data_next  = tx_data;
    tx_valid_next = tx_valid;

    if (accept) begin
      tx_data_next  = owner_data;
      tx_valid_next = 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid_next = 1'b0;
    end

    case (state)
      IDLE: begin
        stall_next = '0;
        if (req0_valid || req1_valid) begin
          state_next = LOCKED;
          if (req0_valid && req1_valid) begin
            grant_next = prio ? 2'b10 : 2'b01;
          end else begin
            grant_next = req1_valid ? 2'b10 : 2'b01;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          stall_next = '0;
          if (owner_last) begin
            state_next = IDLE;
            grant_next = 2'b00;
            prio_next  = grant[0];
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          grant_next = 2'b00;
          prio_next  = grant[0];
        end else if (!owner_valid && (stall_cnt != StallLimit)) begin
          stall_next = stall_cnt + TimeoutWidth'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      prio      <= 1'b0;
      stall_cnt <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      prio      <= prio_next;
      stall_cnt <= stall_next;
      tx_data   <= tx_data_next;
      tx_valid  <= tx_valid_next;
    end
  end

endmodule
